// File: rtl/chip8_fb_renderer.sv
// Copies the 64x32 CHIP-8 display buffer from main RAM into the 128x64 LCD framebuffer,
// doubling every pixel horizontally and vertically (4 framebuffer writes per source byte).
module chip8_fb_renderer #(
    parameter logic [11:0] FB_BASE = 12'hF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_signal,
    output logic [11:0] main_ram_read_address,
    input  logic [7:0]  main_ram_out,
    output logic [9:0]  fb_write_address,
    output logic        fb_write_enable,
    output logic [7:0]  fb_ram_in,
    output logic        busy,
    output logic        finished_signal
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_W0, S_W1, S_W2, S_W3, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  src_q, src_d;
    logic [7:0]  byte_q, byte_d;
    logic [11:0] raddr_q, raddr_d;
    logic [9:0]  waddr_q, waddr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        fin_q, fin_d;

    function automatic logic [7:0] dbl(input logic [3:0] n);
        return {n[3], n[3], n[2], n[2], n[1], n[1], n[0], n[0]};
    endfunction

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        byte_d  = byte_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        fin_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_signal) begin
                    state_d = S_FETCH;
                    src_d   = '0;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                state_d = S_W0;
                byte_d  = main_ram_out;
            end
            S_W0: state_d = S_W1;
            S_W1: state_d = S_W2;
            S_W2: state_d = S_W3;
            S_W3: begin
                if (src_q == 8'hFF) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                    src_d   = src_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Registered outputs are computed for the state being entered, so each
        // write is visible during its own W0..W3 cycle.
        if (state_d == S_FETCH) begin
            raddr_d = FB_BASE + {4'b0000, src_d};
        end

        case (state_d)
            S_W0: begin
                we_d    = 1'b1;
                waddr_d = {src_d[7:3], 1'b0, src_d[2:0], 1'b0};
                wdata_d = dbl(byte_d[7:4]);
            end
            S_W1: begin
                we_d    = 1'b1;
                waddr_d = {src_d[7:3], 1'b0, src_d[2:0], 1'b1};
                wdata_d = dbl(byte_d[3:0]);
            end
            S_W2: begin
                we_d    = 1'b1;
                waddr_d = {src_d[7:3], 1'b1, src_d[2:0], 1'b0};
                wdata_d = dbl(byte_d[7:4]);
            end
            S_W3: begin
                we_d    = 1'b1;
                waddr_d = {src_d[7:3], 1'b1, src_d[2:0], 1'b1};
                wdata_d = dbl(byte_d[3:0]);
            end
            S_DONE:  fin_d = 1'b1;
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            byte_q  <= '0;
            raddr_q <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            byte_q  <= byte_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
        end
    end

    assign main_ram_read_address = raddr_q;
    assign fb_write_address      = waddr_q;
    assign fb_write_enable       = we_q;
    assign fb_ram_in             = wdata_q;
    assign busy                  = busy_q;
    assign finished_signal       = fin_q;

endmodule
